serial_tx: RTL and testbench

Single-line serial transmitter that produces the 1-bit stimulus waveform consumed by the receiving dut input `a`. It accepts a parallel word over a valid/ready handshake and emits a framed stream: start bit, data LSB-first, optional parity, stop bit(s). It replaces hand-timed `a` toggling in benches and serves as the on-chip TX side of the same link.

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_bit_timer.sv | 43 ++++
 rtl/serial_tx.sv | 167 ++++++++++++++++
 tb/tb_serial_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter now, receiver later).
//   tx_state_t  : transmitter frame-sequencing states
//   LINE_IDLE   : level of the line between frames (also the stop-bit level)
//   START_LEVEL : level of the start bit that opens every frame
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer for the serial link.
// Counts clk cycles 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   restart       : force the count back to 0 (holds it there while asserted)
//   bit_done      : high during the last cycle of each bit period
//   bit_done_next : high when the coming cycle will be the last of a bit period;
//                   lets the owner of registered outputs look one cycle ahead
module serial_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic bit_done,
   output logic bit_done_next
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_done = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || bit_done) begin
         cnt_d = '0;
      end
   end

   assign bit_done_next = (cnt_d == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, data LSB-first, optional even parity,
// one or two stop bits. Parallel word enters through a valid/ready handshake.
//   clk      : system clock
//   reset    : asynchronous active-low reset; line returns high at once
//   tx_data  : word to send, sampled on acceptance (tx_valid && tx_ready)
//   tx_valid : source holds a word
//   tx_ready : a word can be accepted this cycle (idle or final stop cycle)
//   tx_out   : serial line, idle high
//   busy     : frame in progress
// All outputs are registered; their next values are derived from the next state.
module serial_tx
   import serial_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy
);

   localparam int unsigned BW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              parity_q, parity_d;
   // Counts data bits, and is reused to count stop bits.
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              tx_out_q, tx_out_d;
   logic              tx_ready_q, tx_ready_d;
   logic              busy_q, busy_d;

   logic accept;
   logic restart;
   logic bit_done;
   logic bit_done_next;

   assign accept  = tx_valid && tx_ready_q;
   // Hold the timer at 0 while idle so every frame starts on a fresh bit period.
   assign restart = (state_q == IDLE) || accept;

   serial_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .restart      (restart),
      .bit_done     (bit_done),
      .bit_done_next(bit_done_next)
   );

   // State register and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         bit_cnt_q  <= '0;
         tx_out_q   <= LINE_IDLE;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_out_q   <= tx_out_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = START;
               shift_d  = tx_data;
               parity_d = ^tx_data;
            end
         end
         START: begin
            if (bit_done) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d   = STOP;
               bit_cnt_d = '0;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (bit_cnt_q == LAST_STOP) begin
                  // tx_ready is only high on this cycle, so accept means back-to-back.
                  if (accept) begin
                     state_d  = START;
                     shift_d  = tx_data;
                     parity_d = ^tx_data;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic, evaluated on the next state so the registered outputs
   // line up with the state they describe.
   always_comb begin
      tx_out_d   = LINE_IDLE;
      tx_ready_d = 1'b0;
      busy_d     = 1'b1;
      unique case (state_d)
         IDLE: begin
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
         START:  tx_out_d = START_LEVEL;
         DATA:   tx_out_d = shift_d[0];
         PARITY: tx_out_d = parity_d;
         STOP: begin
            tx_out_d   = LINE_IDLE;
            tx_ready_d = (bit_cnt_d == LAST_STOP) && bit_done_next;
         end
         default: begin
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   assign tx_out   = tx_out_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx. Three instances cover the default build,
// even parity, and one-cycle bits with two stop bits.
module tb_serial_tx;

   logic       clk;
   logic       reset;
   logic [2:0] valid;
   logic [7:0] dat [3];
   logic [2:0] txo;
   logic [2:0] rdy;
   logic [2:0] bsy;

   int checks;
   int errors;

   serial_tx #(
      .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)
   ) u_dut0 (
      .clk(clk), .reset(reset), .tx_data(dat[0]), .tx_valid(valid[0]),
      .tx_ready(rdy[0]), .tx_out(txo[0]), .busy(bsy[0])
   );

   serial_tx #(
      .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .tx_data(dat[1]), .tx_valid(valid[1]),
      .tx_ready(rdy[1]), .tx_out(txo[1]), .busy(bsy[1])
   );

   serial_tx #(
      .DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(2)
   ) u_dut2 (
      .clk(clk), .reset(reset), .tx_data(dat[2]), .tx_valid(valid[2]),
      .tx_ready(rdy[2]), .tx_out(txo[2]), .busy(bsy[2])
   );

   always #5 clk = ~clk;

   // levels[i] is the line level of the i-th serial bit of the frame.
   typedef struct {
      int unsigned dut;
      logic [7:0]  data;
      logic [11:0] levels;
      int unsigned nbits;
      int unsigned cpb;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   task automatic chk_idle(input int unsigned d, input string tag);
      chk($sformatf("%s dut%0d tx_out", tag, d), 32'(txo[d]), 32'd1);
      chk($sformatf("%s dut%0d busy", tag, d), 32'(bsy[d]), 32'd0);
      chk($sformatf("%s dut%0d tx_ready", tag, d), 32'(rdy[d]), 32'd1);
   endtask

   task automatic run_frame(input vec_t v, input int unsigned idx);
      @(negedge clk);
      dat[v.dut]   = v.data;
      valid[v.dut] = 1'b1;
      @(negedge clk);
      // Now in cycle 0 of the frame; later data changes must be ignored.
      valid[v.dut] = 1'b0;
      dat[v.dut]   = ~v.data;
      for (int i = 0; i < int'(v.nbits); i++) begin
         for (int c = 0; c < int'(v.cpb); c++) begin
            chk($sformatf("vec%0d bit%0d cyc%0d tx_out", idx, i, c),
                32'(txo[v.dut]), 32'(v.levels[i]));
            chk($sformatf("vec%0d bit%0d cyc%0d busy", idx, i, c), 32'(bsy[v.dut]), 32'd1);
            chk($sformatf("vec%0d bit%0d cyc%0d tx_ready", idx, i, c), 32'(rdy[v.dut]),
                32'((i == int'(v.nbits) - 1) && (c == int'(v.cpb) - 1)));
            @(negedge clk);
         end
      end
      chk_idle(v.dut, $sformatf("vec%0d end", idx));
   endtask

   // Reset dut0 asynchronously at the given cycle of a frame.
   task automatic reset_mid(input logic [7:0] data, input int unsigned at_cycle);
      @(negedge clk);
      dat[0]   = data;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (at_cycle) @(negedge clk);
      chk("midreset pre busy", 32'(bsy[0]), 32'd1);
      reset = 1'b0;
      #1;
      chk("midreset async tx_out", 32'(txo[0]), 32'd1);
      chk("midreset async busy", 32'(bsy[0]), 32'd0);
      chk("midreset async tx_ready", 32'(rdy[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         chk_idle(0, $sformatf("postreset k%0d", k));
      end
   endtask

   initial begin
      logic [19:0] b2b;
      int acc;

      checks = 0;
      errors = 0;
      clk    = 1'b0;
      reset  = 1'b1;
      valid  = '0;
      for (int d = 0; d < 3; d++) dat[d] = '0;

      vecs[0] = '{dut: 0, data: 8'hA5, levels: 12'b00_1101001010, nbits: 10, cpb: 4};
      vecs[1] = '{dut: 0, data: 8'h00, levels: 12'b00_1000000000, nbits: 10, cpb: 4};
      vecs[2] = '{dut: 1, data: 8'h07, levels: 12'b0_11_00000111_0, nbits: 11, cpb: 4};
      vecs[3] = '{dut: 1, data: 8'h03, levels: 12'b0_10_00000011_0, nbits: 11, cpb: 4};
      vecs[4] = '{dut: 2, data: 8'h01, levels: 12'b0_11_00000001_0, nbits: 11, cpb: 1};
      vecs[5] = '{dut: 2, data: 8'h80, levels: 12'b0_11_10000000_0, nbits: 11, cpb: 1};

      // Reset then idle.
      #2 reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("inreset dut%0d tx_out", d), 32'(txo[d]), 32'd1);
            chk($sformatf("inreset dut%0d tx_ready", d), 32'(rdy[d]), 32'd0);
            chk($sformatf("inreset dut%0d busy", d), 32'(bsy[d]), 32'd0);
         end
      end
      reset = 1'b1;
      repeat (8) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) chk_idle(d, "idle");
      end

      for (int v = 0; v < 6; v++) run_frame(vecs[v], v);

      // Back-to-back: 0x55 then 0xAA with tx_valid held high.
      b2b = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
      acc = 0;
      @(negedge clk);
      dat[0]   = 8'h55;
      valid[0] = 1'b1;
      if (valid[0] && rdy[0]) acc++;
      @(negedge clk);
      dat[0] = 8'hAA;
      for (int k = 0; k < 80; k++) begin
         chk($sformatf("b2b cyc%0d tx_out", k), 32'(txo[0]), 32'(b2b[k / 4]));
         chk($sformatf("b2b cyc%0d busy", k), 32'(bsy[0]), 32'd1);
         if (k == 40) valid[0] = 1'b0;
         if (valid[0] && rdy[0]) acc++;
         @(negedge clk);
      end
      chk("b2b acceptances", 32'(acc), 32'd2);
      chk_idle(0, "b2b end");

      reset_mid(8'hFF, 15);
      reset_mid(8'h00, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
